product_accumulator: RTL and testbench

//  Downstream stage of the 16x16 array multiplier.

---
 rtl/product_accumulator.sv | 100 ++++++++++
 tb/tb_product_accumulator.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Sums ACC_LEN consecutive unsigned products into a wide accumulator and presents the
// result on a held valid/ready output, saturating or wrapping on overflow.
module product_accumulator #(
    parameter int unsigned PROD_W   = 32,
    parameter int unsigned ACC_W    = 40,
    parameter int unsigned ACC_LEN  = 4,
    parameter bit          SATURATE = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [PROD_W-1:0] in_prod_i,
    input  logic              clear_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ACC_W-1:0]  out_sum_o,
    output logic              out_sat_o
);

    localparam int unsigned    CntW    = $clog2(ACC_LEN + 1);
    localparam int unsigned    SumW    = ACC_W + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(ACC_LEN - 1);

    typedef enum logic {StAcc, StDrain} state_e;

    state_e            state_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;
    logic [CntW-1:0]   cnt_q;
    logic              sticky_q;
    logic              out_valid_q;
    logic [ACC_W-1:0]  out_sum_q;
    logic              out_sat_q;
    logic [ACC_W:0]    sum;
    logic              ovf;
    logic              beat;

    always_comb begin
        sum   = {1'b0, acc_q} + SumW'(in_prod_i);
        ovf   = sum[ACC_W];
        acc_d = sum[ACC_W-1:0];
        // Once clamped, acc stays all-ones since every further add overflows again.
        if (SATURATE && ovf) begin
            acc_d = '1;
        end
    end

    // Clear blocks the beat so a product is never half-counted.
    assign in_ready_o = (state_q == StAcc) && !clear_i;
    assign beat       = in_valid_i && in_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StAcc;
            acc_q       <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StAcc: begin
                    if (clear_i) begin
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        sticky_q <= 1'b0;
                    end else if (beat) begin
                        if (cnt_q == LastCnt) begin
                            out_sum_q   <= acc_d;
                            out_sat_q   <= sticky_q | ovf;
                            out_valid_q <= 1'b1;
                            acc_q       <= '0;
                            cnt_q       <= '0;
                            sticky_q    <= 1'b0;
                            state_q     <= StDrain;
                        end else begin
                            acc_q    <= acc_d;
                            cnt_q    <= cnt_q + CntW'(1);
                            sticky_q <= sticky_q | ovf;
                        end
                    end
                end
                StDrain: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StAcc;
                    end
                end
                default: state_q <= StAcc;
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_sum_o   = out_sum_q;
    assign out_sat_o   = out_sat_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: directed scenarios plus a randomized run against a
// group-sum reference model, on a default instance and two 33-bit saturate/wrap instances.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_prod;
    logic        clear;
    logic        out_ready;

    logic        rdy_a, vld_a, sat_a;
    logic [39:0] sum_a;
    logic        rdy_s, vld_s, sat_s;
    logic [32:0] sum_s;
    logic        rdy_w, vld_w, sat_w;
    logic [32:0] sum_w;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    product_accumulator u_dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy_a),
        .in_prod_i(in_prod), .clear_i(clear), .out_valid_o(vld_a), .out_ready_i(out_ready),
        .out_sum_o(sum_a), .out_sat_o(sat_a)
    );

    product_accumulator #(.ACC_W(33), .SATURATE(1'b1)) u_sat (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy_s),
        .in_prod_i(in_prod), .clear_i(clear), .out_valid_o(vld_s), .out_ready_i(out_ready),
        .out_sum_o(sum_s), .out_sat_o(sat_s)
    );

    product_accumulator #(.ACC_W(33), .SATURATE(1'b0)) u_wrap (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy_w),
        .in_prod_i(in_prod), .clear_i(clear), .out_valid_o(vld_w), .out_ready_i(out_ready),
        .out_sum_o(sum_w), .out_sat_o(sat_w)
    );

    // Reference: a group's result is its plain total, then clamped or reduced modulo 2^w.
    function automatic logic [63:0] model_sum(longint unsigned tot, int w, bit sat);
        longint unsigned lim = longint'(64'd1) << w;
        if (tot >= lim) return sat ? lim - 1 : tot % lim;
        return tot;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] p, input logic c, input logic r);
        in_valid  = v;
        in_prod   = p;
        clear     = c;
        out_ready = r;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (vld_a !== 1'b0) $display("FAIL reset_valid: got %b want 0", vld_a); else passed++;
        total++; if (sum_a !== 40'd0) $display("FAIL reset_sum: got %h want 0", sum_a); else passed++;
        total++; if (sat_a !== 1'b0) $display("FAIL reset_sat: got %b want 0", sat_a); else passed++;
        total++; if (rdy_a !== 1'b1) $display("FAIL reset_ready: got %b want 1", rdy_a); else passed++;
    endtask

    task automatic test_basic();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'(i), 1'b0, 1'b1);
            total++; if (rdy_a !== 1'b1) $display("FAIL basic_ready_beat%0d: got %b want 1", i, rdy_a); else passed++;
            tick();
        end
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        total++; if (vld_a !== 1'b1) $display("FAIL basic_valid: got %b want 1", vld_a); else passed++;
        total++; if (sum_a !== 40'd10) $display("FAIL basic_sum: got %0d want 10", sum_a); else passed++;
        total++; if (sat_a !== 1'b0) $display("FAIL basic_sat: got %b want 0", sat_a); else passed++;
        total++; if (rdy_a !== 1'b0) $display("FAIL basic_ready_gap: got %b want 0", rdy_a); else passed++;
        tick();
        total++; if (vld_a !== 1'b0) $display("FAIL basic_drained: got %b want 0", vld_a); else passed++;
        total++; if (rdy_a !== 1'b1) $display("FAIL basic_ready_back: got %b want 1", rdy_a); else passed++;
    endtask

    task automatic test_backpressure();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'(i * 100), 1'b0, 1'b0);
            tick();
        end
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 32'd7, 1'b0, 1'b0);
            total++; if (rdy_a !== 1'b0) $display("FAIL bp_ready_c%0d: got %b want 0", c, rdy_a); else passed++;
            total++; if (vld_a !== 1'b1) $display("FAIL bp_valid_c%0d: got %b want 1", c, vld_a); else passed++;
            total++; if (sum_a !== 40'd1000) $display("FAIL bp_sum_c%0d: got %0d want 1000", c, sum_a); else passed++;
            tick();
        end
        drive(1'b1, 32'd7, 1'b0, 1'b1);
        total++; if (rdy_a !== 1'b0) $display("FAIL bp_ready_hs: got %b want 0", rdy_a); else passed++;
        tick();
        for (int i = 7; i <= 10; i++) begin
            drive(1'b1, 32'(i), 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        total++; if (vld_a !== 1'b1) $display("FAIL bp_next_valid: got %b want 1", vld_a); else passed++;
        total++; if (sum_a !== 40'd34) $display("FAIL bp_next_sum: got %0d want 34", sum_a); else passed++;
        tick();
    endtask

    task automatic test_clear();
        drive(1'b1, 32'd7, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'd9, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'd1000, 1'b1, 1'b1);
        total++; if (rdy_a !== 1'b0) $display("FAIL clear_ready: got %b want 0", rdy_a); else passed++;
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'd5, 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        total++; if (vld_a !== 1'b1) $display("FAIL clear_valid: got %b want 1", vld_a); else passed++;
        total++; if (sum_a !== 40'd20) $display("FAIL clear_sum: got %0d want 20", sum_a); else passed++;
        tick();
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        total++; if (sum_s !== 33'h1_FFFF_FFFF) $display("FAIL ovf_sat_sum: got %h want 1ffffffff", sum_s); else passed++;
        total++; if (sat_s !== 1'b1) $display("FAIL ovf_sat_flag: got %b want 1", sat_s); else passed++;
        total++; if (sum_w !== 33'h1_FFFF_FFFC) $display("FAIL ovf_wrap_sum: got %h want 1fffffffc", sum_w); else passed++;
        total++; if (sat_w !== 1'b1) $display("FAIL ovf_wrap_flag: got %b want 1", sat_w); else passed++;
        total++; if (sum_a !== 40'h03_FFFF_FFFC) $display("FAIL ovf_wide_sum: got %h want 3fffffffc", sum_a); else passed++;
        total++; if (sat_a !== 1'b0) $display("FAIL ovf_wide_flag: got %b want 0", sat_a); else passed++;
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'd1, 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        total++; if (sum_s !== 33'd4) $display("FAIL ovf_after_sum: got %h want 4", sum_s); else passed++;
        total++; if (sat_s !== 1'b0) $display("FAIL ovf_after_flag: got %b want 0", sat_s); else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'(i * 3), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        total++; if (vld_a !== 1'b1) $display("FAIL rmid_pending: got %b want 1", vld_a); else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total++; if (vld_a !== 1'b0) $display("FAIL rmid_valid: got %b want 0", vld_a); else passed++;
        total++; if (sum_a !== 40'd0) $display("FAIL rmid_sum: got %0d want 0", sum_a); else passed++;
        total++; if (rdy_a !== 1'b1) $display("FAIL rmid_ready: got %b want 1", rdy_a); else passed++;
        drive(1'b1, 32'd50, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'd60, 1'b0, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'(i), 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        total++; if (sum_a !== 40'd10) $display("FAIL rmid_partial: got %0d want 10", sum_a); else passed++;
        tick();
    endtask

    task automatic test_random();
        longint unsigned grp[$];
        longint unsigned tot;
        bit              pending = 1'b0;
        bit              fresh;
        int              results = 0;
        int              cycles  = 0;
        logic            v, r;
        logic [31:0]     p;
        logic [63:0]     exp_a, exp_s, exp_w;
        bit              exp_ovf33;

        do_reset();
        while (results < 100 && cycles < 5000) begin
            v = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 3) != 0);
            p = $urandom;
            drive(v, p, 1'b0, r);
            total++; if (rdy_a !== !pending) $display("FAIL rand_ready_cy%0d: got %b want %b", cycles, rdy_a, !pending); else passed++;
            fresh = 1'b0;
            if (pending) begin
                if (r) pending = 1'b0;
            end else if (v) begin
                grp.push_back(longint'(p));
                if (grp.size() == 4) begin
                    tot = 0;
                    foreach (grp[k]) tot += grp[k];
                    grp.delete();
                    exp_a     = model_sum(tot, 40, 1'b1);
                    exp_s     = model_sum(tot, 33, 1'b1);
                    exp_w     = model_sum(tot, 33, 1'b0);
                    exp_ovf33 = (tot >> 33) != 0;
                    pending   = 1'b1;
                    fresh     = 1'b1;
                end
            end
            tick();
            cycles++;
            total++; if (vld_a !== pending) $display("FAIL rand_valid_cy%0d: got %b want %b", cycles, vld_a, pending); else passed++;
            if (fresh) begin
                results++;
                total++; if (sum_a !== exp_a[39:0]) $display("FAIL rand_sum_r%0d: got %h want %h", results, sum_a, exp_a[39:0]); else passed++;
                total++; if (sum_s !== exp_s[32:0]) $display("FAIL rand_satsum_r%0d: got %h want %h", results, sum_s, exp_s[32:0]); else passed++;
                total++; if (sat_s !== exp_ovf33) $display("FAIL rand_satflag_r%0d: got %b want %b", results, sat_s, exp_ovf33); else passed++;
                total++; if (sum_w !== exp_w[32:0]) $display("FAIL rand_wrapsum_r%0d: got %h want %h", results, sum_w, exp_w[32:0]); else passed++;
                total++; if (sat_w !== exp_ovf33) $display("FAIL rand_wrapflag_r%0d: got %b want %b", results, sat_w, exp_ovf33); else passed++;
            end
        end
        total++; if (results != 100) $display("FAIL rand_budget: got %0d results want 100", results); else passed++;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_prod   = '0;
        clear     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_clear();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
